// File: rtl/pixel_stream_rx_pkg.sv
// Shared definitions for the raster pixel stream (Pixel/Line/Frame) source and sink.
package pixel_stream_rx_pkg;

  typedef enum logic [1:0] {
    StSync,
    StCapture,
    StDrop
  } state_e;

  localparam int unsigned PIX_COLS     = 10;
  localparam int unsigned PIX_ROWS     = 10;
  localparam int unsigned FRAME_PIXELS = PIX_COLS * PIX_ROWS;

  function automatic int unsigned addr_width(input int unsigned pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

  localparam int unsigned PIX_ADDR_W = addr_width(FRAME_PIXELS);

endpackage

// File: rtl/pixel_stream_rx_frame_ram.sv
// Ping-pong frame store: simple dual-port RAM, synchronous write, registered read.
module pixel_stream_rx_frame_ram #(
  parameter int unsigned Depth = 200,
  parameter int unsigned AddrW = 8,
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pixel_stream_rx.sv
// Pixel stream sink: rebuilds (col,row) from framing strobes, checks framing and
// captures complete frames into a two-bank buffer handed to the downstream reader.
module pixel_stream_rx
  import pixel_stream_rx_pkg::*;
#(
  parameter int unsigned COLS   = PIX_COLS,
  parameter int unsigned ROWS   = PIX_ROWS,
  parameter int unsigned ADDR_W = PIX_ADDR_W
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic [7:0]        In_Pixel,
  input  logic              In_Valid,
  input  logic              In_Line,
  input  logic              In_Frame,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [7:0]        Rd_Data,
  output logic              Rd_Avail,
  output logic              Rd_Bank,
  input  logic              Rd_Release,
  output logic              Frame_Ready,
  output logic              Err_Line,
  output logic              Err_Frame,
  output logic [7:0]        Drop_Count
);

  localparam int unsigned ColW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned FramePix = COLS * ROWS;
  localparam int unsigned RamDepth = 2 * FramePix;
  localparam int unsigned RamAw    = $clog2(RamDepth);
  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ColW-1:0]   ecol_q, ecol_d;
  logic [RowW-1:0]   erow_q, erow_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [7:0]        drop_q, drop_d;
  logic              frame_ready_q, frame_ready_d;
  logic              err_line_q, err_line_d;
  logic              err_frame_q, err_frame_d;

  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [RamAw-1:0]  ram_waddr, ram_raddr;
  logic              line_exp, frame_exp, framing_ok, last_pix, start;

  always_comb begin
    state_d       = state_q;
    ecol_d        = ecol_q;
    erow_d        = erow_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    drop_d        = drop_q;
    frame_ready_d = 1'b0;
    err_line_d    = 1'b0;
    err_frame_d   = 1'b0;
    we            = 1'b0;
    start         = 1'b0;
    wr_addr       = ADDR_W'(erow_q) * ADDR_W'(COLS) + ADDR_W'(ecol_q);

    line_exp   = (ecol_q == '0);
    frame_exp  = line_exp && (erow_q == '0);
    framing_ok = (In_Line == line_exp) && (In_Frame == frame_exp);
    last_pix   = (ecol_q == LastCol) && (erow_q == LastRow);

    if (In_Valid) begin
      unique case (state_q)
        StSync: start = In_Frame;
        StCapture, StDrop: begin
          if (!framing_ok) begin
            err_line_d  = (In_Line != line_exp);
            err_frame_d = (In_Frame != frame_exp);
            state_d     = StSync;
            // An unexpected frame strobe is itself a valid frame start.
            start       = In_Frame;
          end else begin
            we = (state_q == StCapture);
            if (last_pix) begin
              state_d = StSync;
              if (state_q == StCapture) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                frame_ready_d     = 1'b1;
              end
            end else if (ecol_q == LastCol) begin
              ecol_d = '0;
              erow_d = erow_q + RowW'(1);
            end else begin
              ecol_d = ecol_q + ColW'(1);
            end
          end
        end
        default: state_d = StSync;
      endcase
    end

    // Bank availability comes from full_q, so a same-cycle release only helps later starts.
    if (start) begin
      ecol_d  = ColW'(1);
      erow_d  = '0;
      wr_addr = '0;
      if (!full_q[wr_bank_q]) begin
        state_d = StCapture;
        we      = 1'b1;
      end else begin
        state_d = StDrop;
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end

    if (Rd_Release && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= StSync;
      ecol_q        <= '0;
      erow_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= 2'b00;
      drop_q        <= '0;
      frame_ready_q <= 1'b0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ecol_q        <= ecol_d;
      erow_q        <= erow_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      drop_q        <= drop_d;
      frame_ready_q <= frame_ready_d;
      err_line_q    <= err_line_d;
      err_frame_q   <= err_frame_d;
    end
  end

  always_comb begin
    ram_waddr = RamAw'(wr_addr) + (wr_bank_q ? RamAw'(FramePix) : RamAw'(0));
    ram_raddr = RamAw'(Rd_Addr) + (rd_bank_q ? RamAw'(FramePix) : RamAw'(0));
  end

  pixel_stream_rx_frame_ram #(
    .Depth(RamDepth),
    .AddrW(RamAw),
    .DataW(8)
  ) u_frame_ram (
    .clk  (Clk),
    .rst_n(nReset),
    .we   (we),
    .waddr(ram_waddr),
    .wdata(In_Pixel),
    .raddr(ram_raddr),
    .rdata(Rd_Data)
  );

  assign Rd_Avail    = |full_q;
  assign Rd_Bank     = rd_bank_q;
  assign Frame_Ready = frame_ready_q;
  assign Err_Line    = err_line_q;
  assign Err_Frame   = err_frame_q;
  assign Drop_Count  = drop_q;

endmodule

// File: tb/tb_pixel_stream_rx.sv
// Scoreboard bench for pixel_stream_rx against a pixel-index level reference model.
module tb_pixel_stream_rx;
  import pixel_stream_rx_pkg::*;

  localparam int C  = 10;
  localparam int R  = 10;
  localparam int N  = C * R;
  localparam int AW = 7;

  logic          Clk = 1'b0;
  logic          nReset = 1'b1;
  logic [7:0]    In_Pixel = '0;
  logic          In_Valid = 1'b0;
  logic          In_Line = 1'b0;
  logic          In_Frame = 1'b0;
  logic [AW-1:0] Rd_Addr = '0;
  logic [7:0]    Rd_Data;
  logic          Rd_Avail;
  logic          Rd_Bank;
  logic          Rd_Release = 1'b0;
  logic          Frame_Ready;
  logic          Err_Line;
  logic          Err_Frame;
  logic [7:0]    Drop_Count;

  pixel_stream_rx #(.COLS(C), .ROWS(R), .ADDR_W(AW)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .In_Pixel   (In_Pixel),
    .In_Valid   (In_Valid),
    .In_Line    (In_Line),
    .In_Frame   (In_Frame),
    .Rd_Addr    (Rd_Addr),
    .Rd_Data    (Rd_Data),
    .Rd_Avail   (Rd_Avail),
    .Rd_Bank    (Rd_Bank),
    .Rd_Release (Rd_Release),
    .Frame_Ready(Frame_Ready),
    .Err_Line   (Err_Line),
    .Err_Frame  (Err_Frame),
    .Drop_Count (Drop_Count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {int cyc; bit fr; bit el; bit ef;} ev_t;
  typedef struct {int cyc; logic [7:0] d;} rd_t;
  ev_t evq[$];
  rd_t rdq[$];

  // Reference model: frame position as a flat pixel index, -1 while hunting for a frame start.
  logic [7:0] m_mem [2][N];
  int m_pos, m_wb, m_rb, m_drop;
  bit m_cap;
  bit m_full [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_cap = 0; m_wb = 0; m_rb = 0; m_drop = 0;
    m_full[0] = 0; m_full[1] = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] p, input bit l, input bit f,
                            input bit rel);
    bit of [2];
    bit restart;
    ev_t e;
    of = m_full;
    restart = 0;
    e.cyc = cyc + 1; e.fr = 0; e.el = 0; e.ef = 0;
    if (v) begin
      if (m_pos < 0) begin
        restart = f;
      end else if (l != (m_pos % C == 0) || f != (m_pos == 0)) begin
        e.el = (l != (m_pos % C == 0));
        e.ef = (f != (m_pos == 0));
        m_pos = -1;
        restart = f;
      end else begin
        if (m_cap) m_mem[m_wb][m_pos] = p;
        if (m_pos == N - 1) begin
          if (m_cap) begin
            m_full[m_wb] = 1; m_wb ^= 1; e.fr = 1;
          end
          m_pos = -1;
        end else begin
          m_pos++;
        end
      end
      if (restart) begin
        if (!of[m_wb]) begin
          m_cap = 1; m_mem[m_wb][0] = p;
        end else begin
          m_cap = 0;
          if (m_drop < 255) m_drop++;
        end
        m_pos = 1;
      end
    end
    if (rel && of[m_rb]) begin
      m_full[m_rb] = 0; m_rb ^= 1;
    end
    if (e.fr || e.el || e.ef) evq.push_back(e);
  endtask

  task automatic drive(input bit v, input logic [7:0] p, input bit l, input bit f, input bit rel);
    In_Valid = v; In_Pixel = p; In_Line = l; In_Frame = f; Rd_Release = rel;
    model_step(v, p, l, f, rel);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input bit rel);
    drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), rel);
  endtask

  task automatic read_px(input int a);
    rd_t r;
    Rd_Addr = AW'(a);
    r.cyc = cyc + 1;
    r.d = m_mem[m_rb][a];
    rdq.push_back(r);
    idle(1'b0);
  endtask

  task automatic read_random(input int n);
    if (m_full[m_rb]) begin
      for (int i = 0; i < n; i++) read_px(int'($urandom_range(N - 1)));
    end
  endtask

  task automatic send_frame(input int first, input int last, input bit ramp, input int vpct,
                            input int err_pos, input int err_kind, input int rel_pos);
    for (int pos = first; pos <= last; pos++) begin
      bit l, f;
      logic [7:0] p;
      while (int'($urandom_range(99)) >= vpct) idle(1'b0);
      l = (pos % C == 0);
      f = (pos == 0);
      if (pos == err_pos) begin
        if (err_kind == 1) l = ~l;
        else if (err_kind == 2) f = ~f;
      end
      p = ramp ? 8'(pos) : 8'($urandom);
      drive(1'b1, p, l, f, pos == rel_pos);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_avail"}, 32'(Rd_Avail), 32'(m_full[0] | m_full[1]));
    chk({tag, "_bank"}, 32'(Rd_Bank), 32'(m_rb));
    chk({tag, "_drop"}, 32'(Drop_Count), 32'(m_drop));
  endtask

  task automatic do_reset();
    In_Valid = 0; In_Line = 0; In_Frame = 0; Rd_Release = 0;
    nReset = 1'b0;
    #2;
    chk("rst_outputs", {Frame_Ready, Err_Line, Err_Frame, Rd_Avail, Rd_Bank},
        32'd0);
    chk("rst_drop", 32'(Drop_Count), 32'd0);
    chk("rst_rd_data", 32'(Rd_Data), 32'd0);
    model_reset();
    evq.delete();
    rdq.delete();
    @(posedge Clk);
    #1;
    nReset = 1'b1;
  endtask

  // Monitor: every output pulse must match the oldest predicted event, in the predicted cycle.
  ev_t mon_e;
  rd_t mon_r;
  always @(negedge Clk) begin
    if (nReset) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        mon_e = evq.pop_front();
        n_checks++; n_fail++;
        $display("FAIL missing_event: got none expected fr/el/ef=%0d%0d%0d at cycle %0d",
                 mon_e.fr, mon_e.el, mon_e.ef, mon_e.cyc);
      end
      if (Frame_Ready || Err_Line || Err_Frame) begin
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          mon_e = evq.pop_front();
          chk("event_fr_el_ef", {Frame_Ready, Err_Line, Err_Frame},
              {mon_e.fr, mon_e.el, mon_e.ef});
        end else begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event: got fr/el/ef=%0d%0d%0d expected none (cycle %0d)",
                   Frame_Ready, Err_Line, Err_Frame, cyc);
        end
      end
      if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
        mon_r = rdq.pop_front();
        chk("rd_data", 32'(Rd_Data), 32'(mon_r.d));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    do_reset();
    check_status("reset");

    // Continuous ramp frame, then spot reads.
    send_frame(0, N - 1, 1'b1, 100, -1, 0, -1);
    check_status("t1");
    chk("t1_bank0", 32'(Rd_Bank), 32'd0);
    read_px(37);
    read_random(5);
    idle(1'b1);

    // Stream joins mid-frame at pixel 45.
    send_frame(45, N - 1, 1'b0, 100, -1, 0, -1);
    check_status("t2_nocapture");
    send_frame(0, N - 1, 1'b0, 100, -1, 0, -1);
    check_status("t2");
    read_random(8);
    idle(1'b1);

    // Spurious line strobe at col 4 row 2, then a clean frame.
    send_frame(0, N - 1, 1'b0, 100, 2 * C + 4, 1, -1);
    check_status("t3_err");
    send_frame(0, N - 1, 1'b0, 100, -1, 0, -1);
    check_status("t3");
    chk("t3_bank0", 32'(Rd_Bank), 32'd0);
    read_random(6);

    // Three frames without release, then release and a fourth frame.
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(0, N - 1, 1'b0, 100, -1, 0, -1);
    check_status("t4_full");
    chk("t4_drop1", 32'(Drop_Count), 32'd1);
    idle(1'b1);
    send_frame(0, N - 1, 1'b0, 100, -1, 0, -1);
    check_status("t4_after");
    chk("t4_bank1", 32'(Rd_Bank), 32'd1);
    read_random(4);
    // Release coinciding with a frame start does not free a bank for that start.
    send_frame(0, N - 1, 1'b0, 100, -1, 0, 0);
    check_status("t4_relstart");

    // Reset in the middle of a frame, then a normal frame.
    send_frame(0, 50, 1'b0, 100, -1, 0, -1);
    do_reset();
    check_status("t6_reset");
    send_frame(0, N - 1, 1'b0, 100, -1, 0, -1);
    check_status("t6");
    read_random(6);
    idle(1'b1);

    // Gappy valid ramp frame, full readback; then completion coinciding with a release.
    send_frame(0, N - 1, 1'b1, 50, -1, 0, -1);
    check_status("t5");
    for (int a = 0; a < N; a++) read_px(a);
    send_frame(0, N - 1, 1'b0, 100, -1, 0, N - 1);
    check_status("t5_relcomplete");
    read_random(4);

    // Random soak: gaps, framing faults and releases at arbitrary points.
    for (int i = 0; i < 14; i++) begin
      int ek, ep, rp;
      ek = int'($urandom_range(3));
      ep = int'($urandom_range(N - 1));
      rp = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1;
      send_frame(0, N - 1, 1'($urandom), int'($urandom_range(100, 40)), ep, ek, rp);
      check_status("soak");
      read_random(3);
      if ($urandom_range(1) == 1) idle(1'b1);
    end

    repeat (4) idle(1'b0);
    chk("events_left", 32'(evq.size()), 32'd0);
    chk("reads_left", 32'(rdq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
